complement32_unit: RTL and testbench

- Registered 32-bit complement unit for the single-cycle RISC-V calculator datapath.
- Produces the two's-complement negation of an ALU operand (srcb path), plus ones'-complement, absolute-value and pass-through modes.
- Registers status flags with the result.
- One pipeline register; valid-qualified input/output.

---
 rtl/complement32_unit.sv | 73 +++++++
 tb/tb_complement32_unit.sv | 130 +++++++++++++
 2 files changed

// File: rtl/complement32_unit.sv
// Registered complement unit: negate, ones' complement, abs, pass-through.
// Define COMPLEMENT32_SAT_EN to saturate overflowing results to max positive.
module complement32_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] din,
    output logic             out_valid,
    output logic [WIDTH-1:0] dout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam logic [1:0] M_NEG  = 2'b00;
    localparam logic [1:0] M_INV  = 2'b01;
    localparam logic [1:0] M_ABS  = 2'b10;
    localparam logic [1:0] M_PASS = 2'b11;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

    logic [WIDTH-1:0] inv;
    logic [WIDTH-1:0] negated;
    logic [WIDTH-1:0] res;
    logic             res_ovf;

    assign inv     = ~din;
    assign negated = inv + 1'b1;

    always_comb begin
        res     = din;
        res_ovf = 1'b0;
        unique case (mode)
            M_NEG:  res = negated;
            M_INV:  res = inv;
            M_ABS:  res = din[WIDTH-1] ? negated : din;
            M_PASS: res = din;
            default: res = din;
        endcase
        // Only the most-negative value has no positive counterpart
        if ((mode == M_NEG || mode == M_ABS) && din == MIN_NEG) begin
            res_ovf = 1'b1;
`ifdef COMPLEMENT32_SAT_EN
            res = MAX_POS;
`else
            res = MIN_NEG;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dout      <= '0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                dout <= res;
                ovf  <= res_ovf;
                zero <= (res == '0);
                neg  <= res[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_complement32_unit.sv
// Directed self-checking bench for complement32_unit.
// Expected overflow results follow COMPLEMENT32_SAT_EN when defined.
module tb_complement32_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  mode;
    logic [31:0] din;
    logic        out_valid;
    logic [31:0] dout;
    logic        ovf;
    logic        zero;
    logic        neg;

    int checks = 0;
    int errors = 0;

    complement32_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .mode      (mode),
        .din       (din),
        .out_valid (out_valid),
        .dout      (dout),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input logic v, input logic [1:0] m,
                         input logic [31:0] d);
        in_valid = v;
        mode     = m;
        din      = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v,
                              input logic o, input logic z,
                              input logic n, input logic [31:0] d);
        logic [35:0] obs;
        logic [35:0] exp;
        obs = {out_valid, ovf, zero, neg, dout};
        exp = {v, o, z, n, d};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got v/ovf/z/n/dout=%b%b%b%b %h expected %b%b%b%b %h",
                   tag, obs[35], obs[34], obs[33], obs[32], obs[31:0],
                   v, o, z, n, d);
        end
    endtask

    logic [31:0] ovf_d;
    logic        ovf_n;

    initial begin
`ifdef COMPLEMENT32_SAT_EN
        ovf_d = 32'h7FFF_FFFF;
        ovf_n = 1'b0;
`else
        ovf_d = 32'h8000_0000;
        ovf_n = 1'b1;
`endif
        rst_n    = 1'b0;
        in_valid = 1'b0;
        mode     = 2'b00;
        din      = '0;

        apply(1'b1, 2'b00, 32'h0000_0005);
        expect_out("reset_edge1", 0, 0, 0, 0, 32'h0);
        apply(1'b0, 2'b00, 32'h0000_0000);
        expect_out("reset_edge2", 0, 0, 0, 0, 32'h0);

        rst_n = 1'b1;
        apply(1'b1, 2'b00, 32'h0000_0234);
        expect_out("neg_234", 1, 0, 0, 1, 32'hFFFF_FDCC);

        apply(1'b1, 2'b00, 32'h0000_0EFF);
        expect_out("stream_neg", 1, 0, 0, 1, 32'hFFFF_F101);
        apply(1'b1, 2'b01, 32'h0000_0234);
        expect_out("stream_inv", 1, 0, 0, 1, 32'hFFFF_FDCB);
        apply(1'b1, 2'b11, 32'h1234_5678);
        expect_out("stream_pass", 1, 0, 0, 0, 32'h1234_5678);

        apply(1'b1, 2'b10, 32'hFFFF_FDCC);
        expect_out("abs_negative", 1, 0, 0, 0, 32'h0000_0234);
        apply(1'b1, 2'b10, 32'h0000_0234);
        expect_out("abs_positive", 1, 0, 0, 0, 32'h0000_0234);
        apply(1'b1, 2'b00, 32'h0000_0000);
        expect_out("neg_zero", 1, 0, 1, 0, 32'h0);
        apply(1'b1, 2'b11, 32'h0000_0000);
        expect_out("pass_zero", 1, 0, 1, 0, 32'h0);

        apply(1'b1, 2'b00, 32'h8000_0000);
        expect_out("neg_min_ovf", 1, 1, 0, ovf_n, ovf_d);
        apply(1'b1, 2'b10, 32'h8000_0000);
        expect_out("abs_min_ovf", 1, 1, 0, ovf_n, ovf_d);
        apply(1'b1, 2'b01, 32'h8000_0000);
        expect_out("inv_min", 1, 0, 0, 0, 32'h7FFF_FFFF);
        apply(1'b1, 2'b00, 32'h7FFF_FFFF);
        expect_out("neg_max", 1, 0, 0, 1, 32'h8000_0001);

        apply(1'b0, 2'b00, 32'h0000_AAAA);
        expect_out("gate_hold1", 0, 0, 0, 1, 32'h8000_0001);
        apply(1'b0, 2'b11, 32'h0000_0000);
        expect_out("gate_hold2", 0, 0, 0, 1, 32'h8000_0001);

        apply(1'b1, 2'b00, 32'h0000_0005);
        expect_out("pre_reset", 1, 0, 0, 1, 32'hFFFF_FFFB);
        rst_n = 1'b0;
        apply(1'b1, 2'b00, 32'h0000_0007);
        expect_out("mid_reset", 0, 0, 0, 0, 32'h0);
        rst_n = 1'b1;
        apply(1'b1, 2'b00, 32'h0000_0001);
        expect_out("post_reset", 1, 0, 0, 1, 32'hFFFF_FFFF);
        apply(1'b0, 2'b00, 32'h0000_0000);
        expect_out("post_idle", 0, 0, 0, 1, 32'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
